// File: rtl/core_decode_unit.sv
// core_decode_unit: registered RV32I decoder producing register indices, immediate and one-hot strobes
module core_decode_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    output logic [4:0]  rd_num,
    output logic [4:0]  rs1_num,
    output logic [4:0]  rs2_num,
    output logic [31:0] imm,
    output logic        i_addi, i_slti, i_sltiu, i_xori, i_ori, i_andi, i_slli, i_srli, i_srai,
    output logic        i_add, i_sub, i_sll, i_slt, i_sltu, i_xor, i_srl, i_sra, i_or, i_and,
    output logic        i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu,
    output logic        i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw,
    output logic        n_inst
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                           OP_MISC = 7'b0001111, OP_SYS = 7'b1110011;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [7:0]  d3;
    logic        z7, a7, oi, ro, bo, lo, so, uf, jf, ii, sh, legal, use_rd, use_rs1, use_rs2;
    logic [31:0] imm_c;
    logic [32:0] s;
    always_comb begin
        op      = inst[6:0];
        f3      = inst[14:12];
        f7      = inst[31:25];
        d3      = 8'b1 << f3;
        z7      = f7 == 7'b0000000;
        a7      = f7 == 7'b0100000;
        oi      = op == OP_IMM;
        ro      = op == OP_OP;
        bo      = op == OP_BRANCH;
        lo      = op == OP_LOAD;
        so      = op == OP_STORE;
        uf      = op == OP_LUI || op == OP_AUIPC;
        jf      = op == OP_JAL;
        ii      = op == OP_JALR || lo || oi || op == OP_MISC || op == OP_SYS;
        sh      = oi && f3[1:0] == 2'b01;
        // strobes only fire for legal funct combinations, so their OR doubles as the legality check
        s       = {so & d3[2], so & d3[1], so & d3[0],
                   lo & d3[5], lo & d3[4], lo & d3[2], lo & d3[1], lo & d3[0],
                   bo & d3[7], bo & d3[6], bo & d3[5], bo & d3[4], bo & d3[1], bo & d3[0],
                   ro & d3[7] & z7, ro & d3[6] & z7, ro & d3[5] & a7, ro & d3[5] & z7, ro & d3[4] & z7,
                   ro & d3[3] & z7, ro & d3[2] & z7, ro & d3[1] & z7, ro & d3[0] & a7, ro & d3[0] & z7,
                   oi & d3[5] & a7, oi & d3[5] & z7, oi & d3[1] & z7, oi & d3[7], oi & d3[6],
                   oi & d3[4], oi & d3[3], oi & d3[2], oi & d3[0]};
        legal   = uf || jf || op == OP_JALR || op == OP_MISC || op == OP_SYS || (|s);
        use_rd  = uf || jf || ii || ro;
        use_rs1 = ii || ro || so || bo;
        use_rs2 = ro || so || bo;
        imm_c   = uf ? {inst[31:12], 12'b0} :
                  jf ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
                  sh ? {27'b0, inst[24:20]} :
                  ii ? {{20{inst[31]}}, inst[31:20]} :
                  so ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                  bo ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} : 32'b0;
    end
    always_ff @(posedge clk) begin
        rd_num  <= (rst || !legal || !use_rd) ? 5'b0 : inst[11:7];
        rs1_num <= (rst || !legal || !use_rs1) ? 5'b0 : inst[19:15];
        rs2_num <= (rst || !legal || !use_rs2) ? 5'b0 : inst[24:20];
        imm     <= (rst || !legal) ? 32'b0 : imm_c;
        n_inst  <= !rst && !legal;
        {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb,
         i_bgeu, i_bltu, i_bge, i_blt, i_bne, i_beq,
         i_and, i_or, i_sra, i_srl, i_xor, i_sltu, i_slt, i_sll, i_sub, i_add,
         i_srai, i_srli, i_slli, i_andi, i_ori, i_xori, i_sltiu, i_slti, i_addi} <= rst ? 33'b0 : s;
    end
endmodule

// File: tb/tb_core_decode_unit.sv
// tb_core_decode_unit: directed scoreboard bench for core_decode_unit
module tb_core_decode_unit;
    logic        clk = 0, rst = 1;
    logic [31:0] inst = 0;
    logic [4:0]  rd_num, rs1_num, rs2_num;
    logic [31:0] imm;
    logic i_addi, i_slti, i_sltiu, i_xori, i_ori, i_andi, i_slli, i_srli, i_srai;
    logic i_add, i_sub, i_sll, i_slt, i_sltu, i_xor, i_srl, i_sra, i_or, i_and;
    logic i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu;
    logic i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw, n_inst;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [32:0] s;
        logic        n;
    } exp_t;
    exp_t sb[$];

    localparam int NONE = -1, ADDI = 0, SRAI = 8, SUB = 10, SRA = 16, BEQ = 19, LW = 27, SW = 32;

    core_decode_unit dut (
        .clk(clk), .rst(rst), .inst(inst), .rd_num(rd_num), .rs1_num(rs1_num), .rs2_num(rs2_num), .imm(imm),
        .i_addi(i_addi), .i_slti(i_slti), .i_sltiu(i_sltiu), .i_xori(i_xori), .i_ori(i_ori), .i_andi(i_andi),
        .i_slli(i_slli), .i_srli(i_srli), .i_srai(i_srai),
        .i_add(i_add), .i_sub(i_sub), .i_sll(i_sll), .i_slt(i_slt), .i_sltu(i_sltu), .i_xor(i_xor),
        .i_srl(i_srl), .i_sra(i_sra), .i_or(i_or), .i_and(i_and),
        .i_beq(i_beq), .i_bne(i_bne), .i_blt(i_blt), .i_bge(i_bge), .i_bltu(i_bltu), .i_bgeu(i_bgeu),
        .i_lb(i_lb), .i_lh(i_lh), .i_lw(i_lw), .i_lbu(i_lbu), .i_lhu(i_lhu),
        .i_sb(i_sb), .i_sh(i_sh), .i_sw(i_sw), .n_inst(n_inst)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [4:0] rd, rs1, rs2, input logic [31:0] im, input int idx,
                                input logic n);
        mk = '{rd: rd, rs1: rs1, rs2: rs2, imm: im, s: (idx < 0) ? 33'b0 : (33'b1 << idx), n: n};
    endfunction

    task automatic chk(input string tag, input logic [32:0] o, input logic [32:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [31:0] i, input exp_t e);
        exp_t x;
        logic [32:0] st;
        @(negedge clk);
        rst  = r;
        inst = i;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x  = sb.pop_front();
        st = {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb, i_bgeu, i_bltu, i_bge, i_blt, i_bne, i_beq,
              i_and, i_or, i_sra, i_srl, i_xor, i_sltu, i_slt, i_sll, i_sub, i_add,
              i_srai, i_srli, i_slli, i_andi, i_ori, i_xori, i_sltiu, i_slti, i_addi};
        chk({tag, ".rd"}, {28'b0, rd_num}, {28'b0, x.rd});
        chk({tag, ".rs1"}, {28'b0, rs1_num}, {28'b0, x.rs1});
        chk({tag, ".rs2"}, {28'b0, rs2_num}, {28'b0, x.rs2});
        chk({tag, ".imm"}, {1'b0, imm}, {1'b0, x.imm});
        chk({tag, ".strobes"}, st, x.s);
        chk({tag, ".n_inst"}, {32'b0, n_inst}, {32'b0, x.n});
    endtask

    initial begin
        step("reset_lui", 1, 32'hFAAAF0B7, mk(0, 0, 0, 0, NONE, 0));
        step("lui",       0, 32'hFAAAF0B7, mk(1, 0, 0, 32'hFAAAF000, NONE, 0));
        step("jal",       0, 32'h7FE991EF, mk(3, 0, 0, 32'h000997FE, NONE, 0));
        step("auipc",     0, 32'h00001517, mk(10, 0, 0, 32'h00001000, NONE, 0));
        step("sra",       0, 32'h4013DAB3, mk(21, 7, 1, 0, SRA, 0));
        step("sub",       0, 32'h403100B3, mk(1, 2, 3, 0, SUB, 0));
        step("beq_neg",   0, 32'hFE208EE3, mk(0, 1, 2, 32'hFFFFFFFC, BEQ, 0));
        step("lw_neg",    0, 32'hFF852283, mk(5, 10, 0, 32'hFFFFFFF8, LW, 0));
        step("sw_neg",    0, 32'hFE612A23, mk(0, 2, 6, 32'hFFFFFFF4, SW, 0));
        step("addi_min",  0, 32'h80020193, mk(3, 4, 0, 32'hFFFFF800, ADDI, 0));
        step("srai",      0, 32'h40735293, mk(5, 6, 0, 32'h00000007, SRAI, 0));
        step("ecall",     0, 32'h00000073, mk(0, 0, 0, 0, NONE, 0));
        step("all_ones",  0, 32'hFFFFFFFF, mk(0, 0, 0, 0, NONE, 1));
        step("op_f7_1",   0, 32'h023100B3, mk(0, 0, 0, 0, NONE, 1));
        step("slli_f7_1", 0, 32'h02109093, mk(0, 0, 0, 0, NONE, 1));
        step("br_f3_010", 0, 32'hFE20AEE3, mk(0, 0, 0, 0, NONE, 1));
        step("low_bits",  0, 32'h00000010, mk(0, 0, 0, 0, NONE, 1));
        step("reset_sra", 1, 32'h4013DAB3, mk(0, 0, 0, 0, NONE, 0));
        step("reset_bad", 1, 32'hFFFFFFFF, mk(0, 0, 0, 0, NONE, 0));
        step("post_rst",  0, 32'hFAAAF0B7, mk(1, 0, 0, 32'hFAAAF000, NONE, 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
